// File: rtl/i2s_receiver.sv
// I2S target-side receiver: oversamples sck/ws/sd with clk, frames left/right words
// on ws transitions and hands them out through a 2-entry ready/valid buffer.
module i2s_receiver #(
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sck,
  input  logic                  ws,
  input  logic                  sd,
  input  logic                  o_ready,
  output logic                  o_valid,
  output logic                  o_ws,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_locked,
  output logic                  o_overrun
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DATA_WIDTH);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    S_SYNC,
    S_RECV
  } state_t;

  // Pin synchronizers; sck gets a third stage for rising-edge detection.
  logic sck_q1, sck_q2, sck_q3;
  logic ws_q1, ws_q2;
  logic sd_q1, sd_q2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q1 <= 1'b0;
      sck_q2 <= 1'b0;
      sck_q3 <= 1'b0;
      ws_q1  <= 1'b0;
      ws_q2  <= 1'b0;
      sd_q1  <= 1'b0;
      sd_q2  <= 1'b0;
    end else begin
      sck_q1 <= sck;
      sck_q2 <= sck_q1;
      sck_q3 <= sck_q2;
      ws_q1  <= ws;
      ws_q2  <= ws_q1;
      sd_q1  <= sd;
      sd_q2  <= sd_q1;
    end
  end

  logic sample;
  logic ws_edge;
  assign sample = sck_q2 & ~sck_q3;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, shift_ins;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]         to_cnt_q, to_cnt_d;
  logic                  ws_prev_q, ws_prev_d;
  logic                  push;
  logic [DATA_WIDTH:0]   push_word;

  assign ws_edge = (ws_q2 != ws_prev_q);

  // Current bit dropped into its MSB-first slot; bits past DATA_WIDTH have no slot.
  always_comb begin
    shift_ins = shift_q;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (bit_cnt_q == CW'(DATA_WIDTH - 1 - i)) begin
        shift_ins[i] = sd_q2;
      end
    end
  end

  assign push_word = {ws_prev_q, shift_ins};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_SYNC;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      to_cnt_q  <= '0;
      ws_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      to_cnt_q  <= to_cnt_d;
      ws_prev_q <= ws_prev_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    to_cnt_d  = to_cnt_q;
    ws_prev_d = ws_prev_q;
    push      = 1'b0;
    case (state_q)
      S_SYNC: begin
        to_cnt_d = '0;
        if (sample) begin
          ws_prev_d = ws_q2;
          if (ws_edge) begin
            shift_d   = '0;
            bit_cnt_d = '0;
            state_d   = S_RECV;
          end
        end
      end
      S_RECV: begin
        if (sample) begin
          ws_prev_d = ws_q2;
          to_cnt_d  = '0;
          if (ws_edge) begin
            // This bit is the LSB of the word that just ended.
            push      = 1'b1;
            shift_d   = '0;
            bit_cnt_d = '0;
          end else begin
            shift_d = shift_ins;
            if (bit_cnt_q < CNT_MAX) begin
              bit_cnt_d = bit_cnt_q + CW'(1);
            end
          end
        end else if (to_cnt_q == TO_LAST) begin
          state_d   = S_SYNC;
          shift_d   = '0;
          bit_cnt_d = '0;
          to_cnt_d  = '0;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      default: state_d = S_SYNC;
    endcase
  end

  assign o_locked = (state_q == S_RECV);

  // Two-entry output buffer: entry = {channel, word}.
  logic [DATA_WIDTH:0] mem_q [2];
  logic                wr_ptr_q, rd_ptr_q;
  logic [1:0]          count_q, count_d;
  logic                full, pop, push_ok;
  logic                overrun_q;

  assign full    = (count_q == 2'd2);
  assign pop     = o_valid & o_ready;
  assign push_ok = push & ~full;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      overrun_q <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_word;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
      // Fullness is judged before any same-cycle pop, so a full buffer always drops.
      if (push && full) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign o_valid   = (count_q != 2'd0);
  assign o_overrun = overrun_q;
  assign {o_ws, o_data} = mem_q[rd_ptr_q];

endmodule

// File: doc/i2s_receiver.md
# i2s_receiver

I2S target-side receiver: the far end of the I2S link driven by `i2s_controller`. It oversamples the external `sck`/`ws`/`sd` pins with the system clock and recovers left/right audio words. Each word is delivered on a ready/valid output port through a 2-entry buffer. It sits between the board pins (codec or peer controller) and downstream sample consumers.

## Interface
Parameters:
- `DATA_WIDTH`, default 16: output word width; received bits beyond this are discarded, missing bits are zero-filled.
- `TIMEOUT_CYCLES`, default 1024: `clk` cycles without an `sck` rising edge before lock is dropped.

Ports:
- `clk` in 1: system clock. One clock domain; `sck` is treated as data, not as a clock.
- `rst` in 1: reset, synchronous and active-high.
- `sck` in 1: external bit clock, asynchronous.
- `ws` in 1: external word select, asynchronous. 0 = left, 1 = right.
- `sd` in 1: external serial data, asynchronous, MSB first.
- `o_ready` in 1: downstream ready.
- `o_valid` out 1: buffer head is valid.
- `o_ws` out 1: channel of the head word.
- `o_data` out `DATA_WIDTH`: head word, left-justified.
- `o_locked` out 1: word framing established.
- `o_overrun` out 1: sticky flag, a completed word was dropped because the buffer was full.

## Operation
- **Input synchronizer.** `sck`, `ws` and `sd` each pass through two flops (q1, q2). `sck` has an extra q3 flop.
- **Sample event.** Asserted in the cycle where sck_q2=1 and sck_q3=0. All sampling uses ws_q2 and sd_q2 in that cycle.
- **`ws_prev`** holds ws_q2 from the previous sample event.
- **State machine:**
  - S_SYNC (reset state, `o_locked`=0):
    - Sample events are ignored except for updating `ws_prev`.
    - On the first sample event with ws_q2 != `ws_prev`: clear `shift` and `bit_count`, go to S_RECV. The partial word is discarded.
  - S_RECV (`o_locked`=1), on each sample event:
    - If ws_q2 == `ws_prev`: if `bit_count` < `DATA_WIDTH`, set shift[DATA_WIDTH-1-bit_count] = sd_q2. Then `bit_count` increments, saturating at `DATA_WIDTH`.
    - If ws_q2 != `ws_prev`: this bit is the LSB of the word for channel `ws_prev`. Store it as above, then push {`ws_prev`, `shift`} to the buffer. Clear `shift` and `bit_count`. The next sample event is the MSB of the new word.
    - In both cases `ws_prev` <= ws_q2.
    - A timeout counter is cleared on every sample event. When it reaches `TIMEOUT_CYCLES`-1 without one, return to S_SYNC and drop the partial word. Buffered words are kept.
- **Word width rules.**
  - Words longer than `DATA_WIDTH`: only the first `DATA_WIDTH` bits (MSBs) are kept.
  - Words shorter than `DATA_WIDTH`: the LSBs stay 0.
- **Buffer.** 2-entry FIFO.
  - Pop on `o_valid` && `o_ready`.
  - A push arriving while full is dropped and sets `o_overrun`. This holds even when a pop happens in the same cycle.
  - Simultaneous push and pop with 1 entry: both take effect, count stays 1.
  - `o_overrun` clears only on `rst`.

## Timing
- **Reset values:** `o_valid`=0, `o_ws`=0, `o_data`=0, `o_locked`=0, `o_overrun`=0. Buffer empty, state S_SYNC, all counters 0, `ws_prev`=0.
- **Minimum pulse widths:** `sck` high and low must each last ≥2 `clk` periods. `ws`/`sd` must be stable from the `sck` rising edge through 3 `clk` cycles after it.
- **Push latency:**
  - Edge 1: sck pin high captured into q1.
  - Between edges 2 and 3: sample event.
  - Edge 3: buffer write.
  - `o_valid` and `o_data` are valid after edge 3.
- **Output stability:** `o_data`/`o_ws` are held stable while `o_valid`=1 and `o_ready`=0. The head advances on the edge after a pop.
- **Reset mid-word:** next cycle everything is at reset values. Buffered and partial words are lost, and a full ws transition is required to relock.
- **`o_locked`** rises on the edge that enters S_RECV. It falls on the timeout edge.

## Test plan
- **Basic stereo receive.** Reset. Drive `sck` at `clk`/8 for 2 idle frames, then frames of 16 bits, left=0xA5C3 and right=0x1234, `o_ready`=1. Required: first output pair (`o_ws`=0, 0xA5C3) then (`o_ws`=1, 0x1234); `o_locked`=1 after the first ws edge; no output for the pre-lock partial word.
- **Long words.** 24-bit words, left=0xABCDEF. Required: `o_data`=0xABCD.
- **Short words.** 8-bit words, right=0x5A. Required: `o_data`=0x5A00.
- **Backpressure and overrun.** `o_ready`=0 for 3 completed words W0, W1, W2. Required: `o_overrun`=1 after W2's push; releasing `o_ready` yields W0 then W1 only, with `o_data` stable while stalled.
- **Timeout.** Stop `sck` mid-word for `TIMEOUT_CYCLES`. Required: `o_locked`=0 at exactly `TIMEOUT_CYCLES` cycles after the last sample event, no partial word output. Restarting `sck` relocks on the next ws edge.
- **Reset mid-word.** Assert `rst` for 1 cycle with 1 buffered word and 5 bits shifted. Required: `o_valid`=0 and `o_locked`=0 the next cycle; the first word after relock is correct.
